// File: rtl/updn_cnt_pkg.sv
// Shared constants and the generic next-count step for the parametrised up/down counter.
// The step works at MAX_WIDTH+1 bits so any legal WIDTH fits without overflow.
package updn_cnt_pkg;

    localparam logic CNT_UP    = 1'b0;
    localparam logic CNT_DOWN  = 1'b1;
    localparam int   MAX_WIDTH = 32;

    typedef logic [MAX_WIDTH:0] cnt_ext_t;

    typedef struct packed {
        logic     wrap;
        cnt_ext_t next;
    } cnt_step_t;

    // One enabled count step: returns {wrap, next} for the given value and direction.
    function automatic cnt_step_t cnt_next(
        input cnt_ext_t value,
        input logic     dir,
        input cnt_ext_t max,
        input logic     saturate
    );
        cnt_step_t r;
        r.wrap = 1'b0;
        r.next = value;
        if (dir == CNT_UP) begin
            if (value < max) begin
                r.next = value + cnt_ext_t'(1);
            end else if (!saturate) begin
                r.next = '0;
                r.wrap = 1'b1;
            end
        end else begin
            if (value != '0) begin
                r.next = value - cnt_ext_t'(1);
            end else if (!saturate) begin
                r.next = max;
                r.wrap = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/updn_cnt_next.sv
// Combinational next-count and terminal-count logic for updn_counter_param.
// Holds no state; the top level decides whether the step is taken.
module updn_cnt_next
    import updn_cnt_pkg::*;
#(
    parameter int unsigned          WIDTH     = 4,
    parameter logic [WIDTH-1:0]     MAX_COUNT = {WIDTH{1'b1}},
    parameter bit                   SATURATE  = 1'b0
) (
    input  logic [WIDTH-1:0] q,
    input  logic             en,
    input  logic             ctrl,
    output logic [WIDTH-1:0] next_q,
    output logic             next_wrap,
    output logic             tc
);

    cnt_step_t step;
    logic      unused_hi;

    always_comb begin
        step = cnt_next(cnt_ext_t'(q), ctrl, cnt_ext_t'(MAX_COUNT), SATURATE);
    end

    assign next_q    = step.next[WIDTH-1:0];
    assign next_wrap = step.wrap;
    // Upper bits are always zero because the step never exceeds MAX_COUNT.
    assign unused_hi = |step.next[MAX_WIDTH:WIDTH];

    assign tc = en & (((ctrl == CNT_UP)   & (q == MAX_COUNT)) |
                      ((ctrl == CNT_DOWN) & (q == '0)));

endmodule

// File: rtl/updn_counter_param.sv
// Parametrised up/down counter with clear, wrap/saturate mode, tc and wrap flags.
// Define UPDN_CNT_LOAD_EN to add the load/d parallel-load ports.
module updn_counter_param
    import updn_cnt_pkg::*;
#(
    parameter int unsigned          WIDTH     = 4,
    parameter logic [WIDTH-1:0]     MAX_COUNT = {WIDTH{1'b1}},
    parameter bit                   SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ctrl,
    input  logic             clr,
`ifdef UPDN_CNT_LOAD_EN
    input  logic             load,
    input  logic [WIDTH-1:0] d,
`endif
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("updn_counter_param: WIDTH must be in 1..32");
    end
    if (MAX_COUNT == '0) begin : g_bad_max
        $error("updn_counter_param: MAX_COUNT must be at least 1");
    end

    logic [WIDTH-1:0] step_q;
    logic             step_wrap;
    logic [WIDTH-1:0] q_d;
    logic             wrap_d;
    logic             armed;

    updn_cnt_next #(
        .WIDTH     (WIDTH),
        .MAX_COUNT (MAX_COUNT),
        .SATURATE  (SATURATE)
    ) u_next (
        .q         (q),
        .en        (en),
        .ctrl      (ctrl),
        .next_q    (step_q),
        .next_wrap (step_wrap),
        .tc        (tc)
    );

    // NOTE: q_d and wrap_d get defaults first so no path through the priority chain infers a latch.
    always_comb begin
        q_d    = q;
        wrap_d = 1'b0;
        // The first edge after reset release only arms the counter.
        if (armed) begin
            if (clr) begin
                q_d = '0;
            end
`ifdef UPDN_CNT_LOAD_EN
            else if (load) begin
                q_d = (d > MAX_COUNT) ? MAX_COUNT : d;
            end
`endif
            else if (en) begin
                q_d    = step_q;
                wrap_d = step_wrap;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q     <= '0;
            wrap  <= 1'b0;
            armed <= 1'b0;
        end else begin
            q     <= q_d;
            wrap  <= wrap_d;
            armed <= 1'b1;
        end
    end

endmodule

// File: tb/tb_updn_counter_param.sv
// Self-checking bench for updn_counter_param: three configurations share stimulus
// (4-bit wrap, MAX_COUNT=9 wrap, MAX_COUNT=9 saturate) against an arithmetic model.
`timescale 1ns/1ps
module tb_updn_counter_param;

    localparam int N = 3;
    localparam int MAXV [N] = '{15, 9, 9};
    localparam bit SATV [N] = '{1'b0, 1'b0, 1'b1};

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       ctrl;
    logic       clr;
`ifdef UPDN_CNT_LOAD_EN
    logic       load;
    logic [3:0] d;
`endif
    logic [3:0] q_o    [N];
    logic       tc_o   [N];
    logic       wrap_o [N];

    int n_checks = 0;
    int n_fail   = 0;

    int mq [N];
    bit mw [N];
    bit marmed;

    always #5 clk = ~clk;

    updn_counter_param #(.WIDTH(4)) u_def (
        .clk(clk), .rst(rst), .en(en), .ctrl(ctrl), .clr(clr),
`ifdef UPDN_CNT_LOAD_EN
        .load(load), .d(d),
`endif
        .q(q_o[0]), .tc(tc_o[0]), .wrap(wrap_o[0])
    );

    updn_counter_param #(.WIDTH(4), .MAX_COUNT(4'd9)) u_m9 (
        .clk(clk), .rst(rst), .en(en), .ctrl(ctrl), .clr(clr),
`ifdef UPDN_CNT_LOAD_EN
        .load(load), .d(d),
`endif
        .q(q_o[1]), .tc(tc_o[1]), .wrap(wrap_o[1])
    );

    updn_counter_param #(.WIDTH(4), .MAX_COUNT(4'd9), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .ctrl(ctrl), .clr(clr),
`ifdef UPDN_CNT_LOAD_EN
        .load(load), .d(d),
`endif
        .q(q_o[2]), .tc(tc_o[2]), .wrap(wrap_o[2])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            mq[i] = 0;
            mw[i] = 1'b0;
        end
        marmed = 1'b0;
    endfunction

    // Count modulo MAX+1, or clamp at the range ends in saturate mode.
    function automatic void model_edge();
        int span;
        int n;
        if (!marmed) begin
            marmed = 1'b1;
            return;
        end
        for (int i = 0; i < N; i++) begin
            span  = MAXV[i] + 1;
            mw[i] = 1'b0;
            if (clr) begin
                mq[i] = 0;
            end
`ifdef UPDN_CNT_LOAD_EN
            else if (load) begin
                mq[i] = (int'(d) > MAXV[i]) ? MAXV[i] : int'(d);
            end
`endif
            else if (en) begin
                n = mq[i] + (ctrl ? -1 : 1);
                if (n >= 0 && n < span) begin
                    mq[i] = n;
                end else if (!SATV[i]) begin
                    mq[i] = (n + span) % span;
                    mw[i] = 1'b1;
                end
            end
        end
    endfunction

    function automatic bit model_tc(input int i);
        return en && ((!ctrl && mq[i] == MAXV[i]) || (ctrl && mq[i] == 0));
    endfunction

    task automatic check_all(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s q[%0d]", tag, i), q_o[i], mq[i]);
            check($sformatf("%s wrap[%0d]", tag, i), wrap_o[i], mw[i]);
            check($sformatf("%s tc[%0d]", tag, i), tc_o[i], model_tc(i));
        end
    endtask

    // Inputs change on the falling edge; outputs are compared there too.
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic drive(input bit c, input bit e, input bit dir);
        clr  = c;
        en   = e;
        ctrl = dir;
    endtask

`ifdef UPDN_CNT_LOAD_EN
    task automatic drive_load(input bit l, input logic [3:0] dv);
        load = l;
        d    = dv;
    endtask
`endif

    typedef struct {
        bit clr;
        bit en;
        bit ctrl;
        int q9;
        bit w9;
        int qs;
        bit ws;
    } vec_t;

    vec_t vecs [17];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // {clr, en, ctrl, q MAX9-wrap, wrap, q MAX9-sat, wrap}
        vecs = '{
            '{1, 0, 0, 0, 0, 0, 0},
            '{0, 1, 1, 9, 1, 0, 0},
            '{0, 1, 1, 8, 0, 0, 0},
            '{0, 1, 1, 7, 0, 0, 0},
            '{0, 1, 0, 8, 0, 1, 0},
            '{0, 1, 0, 9, 0, 2, 0},
            '{0, 1, 0, 0, 1, 3, 0},
            '{0, 0, 0, 0, 0, 3, 0},
            '{0, 1, 0, 1, 0, 4, 0},
            '{1, 1, 0, 0, 0, 0, 0},
            '{0, 1, 0, 1, 0, 1, 0},
            '{0, 1, 0, 2, 0, 2, 0},
            '{0, 1, 0, 3, 0, 3, 0},
            '{0, 1, 0, 4, 0, 4, 0},
            '{0, 1, 1, 3, 0, 3, 0},
            '{0, 1, 0, 4, 0, 4, 0},
            '{0, 1, 1, 3, 0, 3, 0}
        };

        rst = 1'b0;
        drive(0, 0, 0);
`ifdef UPDN_CNT_LOAD_EN
        drive_load(0, 4'd0);
`endif
        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset");

        // Release, then the synchronisation edge leaves q at 0 even with en=1.
        rst = 1'b1;
        drive(0, 1, 0);
        tick("sync");
        check("sync q_def", q_o[0], 0);

        // Default 4-bit counter: 0..15 then wraps to 0 with a one-cycle pulse.
        for (int i = 1; i <= 17; i++) begin
            #1;
            check($sformatf("up17 tc i=%0d", i), tc_o[0], ((i - 1) % 16) == 15);
            tick("up17");
            check($sformatf("up17 q i=%0d", i), q_o[0], i % 16);
            check($sformatf("up17 wrap i=%0d", i), wrap_o[0], i == 16);
        end

        foreach (vecs[k]) begin
            drive(vecs[k].clr, vecs[k].en, vecs[k].ctrl);
            tick("tbl");
            check($sformatf("tbl%0d q_m9", k), q_o[1], vecs[k].q9);
            check($sformatf("tbl%0d wrap_m9", k), wrap_o[1], vecs[k].w9);
            check($sformatf("tbl%0d q_sat", k), q_o[2], vecs[k].qs);
            check($sformatf("tbl%0d wrap_sat", k), wrap_o[2], vecs[k].ws);
        end

        // Saturate holds at 9 while the wrapping twin rolls over.
        drive(1, 0, 0);
        tick("sat_clr");
        drive(0, 1, 0);
        for (int i = 1; i <= 12; i++) begin
            tick("sat_up");
            check($sformatf("sat_up q_sat i=%0d", i), q_o[2], (i > 9) ? 9 : i);
            check($sformatf("sat_up wrap_sat i=%0d", i), wrap_o[2], 0);
            check($sformatf("sat_up q_m9 i=%0d", i), q_o[1], i % 10);
            check($sformatf("sat_up wrap_m9 i=%0d", i), wrap_o[1], i == 10);
        end
        drive(1, 0, 0);
        tick("sat_clr2");
        drive(0, 1, 1);
        #1;
        check("sat_dn tc_sat", tc_o[2], 1);
        for (int i = 1; i <= 3; i++) begin
            tick("sat_dn");
            check($sformatf("sat_dn q_sat i=%0d", i), q_o[2], 0);
            check($sformatf("sat_dn tc_sat i=%0d", i), tc_o[2], 1);
        end

`ifdef UPDN_CNT_LOAD_EN
        drive(1, 0, 0);
        tick("ld_clr");
        drive(0, 0, 0);
        drive_load(1, 4'd12);
        tick("ld12");
        check("ld12 q_def", q_o[0], 12);
        check("ld12 q_m9", q_o[1], 9);
        check("ld12 q_sat", q_o[2], 9);
        drive(1, 0, 0);
        drive_load(1, 4'd7);
        tick("ld_vs_clr");
        check("ld_vs_clr q_m9", q_o[1], 0);
        drive(0, 1, 0);
        drive_load(1, 4'd5);
        tick("ld_vs_en");
        check("ld_vs_en q_m9", q_o[1], 5);
        check("ld_vs_en q_def", q_o[0], 5);
        drive_load(0, 4'd0);
`endif

        // Asynchronous reset in the middle of a cycle at q=7.
        drive(1, 0, 0);
        tick("ar_clr");
        drive(0, 1, 0);
        repeat (7) tick("ar_up");
        check("ar pre q_def", q_o[0], 7);
        #1 rst = 1'b0;
        #1;
        model_reset();
        check_all("ar_async");
        #1 rst = 1'b1;
        tick("ar_sync");
        check("ar sync q_def", q_o[0], 0);
        tick("ar_first");
        check("ar first q_def", q_o[0], 1);

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
`ifdef UPDN_CNT_LOAD_EN
            drive_load($urandom_range(0, 7) == 0, 4'($urandom_range(0, 15)));
`endif
            tick("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
